// File: rtl/pam_serial_receiver.sv
// rtl/pam_serial_receiver.sv - PAM serial link receiver: oversampled deserializer feeding a byte-wide FIFO write port
module pam_serial_receiver #(
  parameter int DATA_LENGTH = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   sdata,
  input  logic                   bclk,
  input  logic                   nsync,
  input  logic                   full,
  output logic [7:0]             wdata,
  output logic                   write,
  output logic [DATA_LENGTH-1:0] word,
  output logic                   word_valid,
  output logic                   frame_err,
  output logic                   overflow,
  output logic                   busy
);

  localparam int NBYTES = DATA_LENGTH / 8;
  localparam int CW     = $clog2(DATA_LENGTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, WRITE} state_t;

  logic [SYNC_STAGES-1:0] bclk_sync_q, nsync_sync_q, sdata_sync_q;
  logic                   bclk_s, nsync_s, sdata_s;
  logic                   bclk_q, nsync_q;
  logic                   bclk_fall_q, sync_fall_q, sync_rise_q;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [DATA_LENGTH-1:0] shreg_q, shreg_d;
  logic [DATA_LENGTH-1:0] word_q, word_d;
  logic [DATA_LENGTH-1:0] shift_in;
  logic [1:0]             idx_q, idx_d;
  logic [7:0]             wdata_q, wdata_d;
  logic                   write_q, write_d;
  logic                   word_valid_q, word_valid_d;
  logic                   frame_err_q, frame_err_d;
  logic                   overflow_q, overflow_d;

  assign bclk_s  = bclk_sync_q[SYNC_STAGES-1];
  assign nsync_s = nsync_sync_q[SYNC_STAGES-1];
  assign sdata_s = sdata_sync_q[SYNC_STAGES-1];

  // Synchronizers and registered edge strobes run regardless of enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      bclk_sync_q  <= '0;
      nsync_sync_q <= '0;
      sdata_sync_q <= '0;
      bclk_q       <= 1'b0;
      nsync_q      <= 1'b0;
      bclk_fall_q  <= 1'b0;
      sync_fall_q  <= 1'b0;
      sync_rise_q  <= 1'b0;
    end else begin
      bclk_sync_q  <= {bclk_sync_q[SYNC_STAGES-2:0], bclk};
      nsync_sync_q <= {nsync_sync_q[SYNC_STAGES-2:0], nsync};
      sdata_sync_q <= {sdata_sync_q[SYNC_STAGES-2:0], sdata};
      bclk_q       <= bclk_s;
      nsync_q      <= nsync_s;
      bclk_fall_q  <= bclk_q & ~bclk_s;
      sync_fall_q  <= nsync_q & ~nsync_s;
      sync_rise_q  <= ~nsync_q & nsync_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      shreg_q      <= '0;
      word_q       <= '0;
      idx_q        <= '0;
      wdata_q      <= '0;
      write_q      <= 1'b0;
      word_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shreg_q      <= shreg_d;
      word_q       <= word_d;
      idx_q        <= idx_d;
      wdata_q      <= wdata_d;
      write_q      <= write_d;
      word_valid_q <= word_valid_d;
      frame_err_q  <= frame_err_d;
      overflow_q   <= overflow_d;
    end
  end

  assign shift_in = {shreg_q[DATA_LENGTH-2:0], sdata_s};

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shreg_d      = shreg_q;
    word_d       = word_q;
    idx_d        = idx_q;
    wdata_d      = wdata_q;
    write_d      = 1'b0;
    word_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    overflow_d   = 1'b0;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (sync_fall_q) begin
            cnt_d   = '0;
            shreg_d = '0;
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          if (bclk_fall_q) begin
            shreg_d = shift_in;
            cnt_d   = cnt_q + 1'b1;
          end
          // A completing bit wins over a simultaneous sync_rise.
          if (bclk_fall_q && (cnt_q == CW'(DATA_LENGTH - 1))) begin
            word_d       = shift_in;
            word_valid_d = 1'b1;
            idx_d        = '0;
            state_d      = WRITE;
          end else if (sync_rise_q) begin
            frame_err_d = 1'b1;
            state_d     = IDLE;
          end
        end
        WRITE: begin
          if (sync_fall_q) begin
            overflow_d = 1'b1;
          end
          if (!full) begin
            write_d = 1'b1;
            wdata_d = word_q[{idx_q, 3'b000} +: 8];
            idx_d   = idx_q + 2'd1;
            if (idx_q == 2'(NBYTES - 1)) begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign wdata      = wdata_q;
  assign write      = write_q;
  assign word       = word_q;
  assign word_valid = word_valid_q;
  assign frame_err  = frame_err_q;
  assign overflow   = overflow_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_pam_serial_receiver.sv
// tb/tb_pam_serial_receiver.sv - scoreboard bench for pam_serial_receiver with directed frames
module tb_pam_serial_receiver;

  localparam int DL = 24;

  logic          clk = 1'b0;
  logic          rst, enable, sdata, bclk, nsync, full;
  logic [7:0]    wdata;
  logic          write, word_valid, frame_err, overflow, busy;
  logic [DL-1:0] word;

  pam_serial_receiver #(.DATA_LENGTH(DL), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .enable(enable), .sdata(sdata), .bclk(bclk),
    .nsync(nsync), .full(full), .wdata(wdata), .write(write), .word(word),
    .word_valid(word_valid), .frame_err(frame_err), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;

  logic [7:0]    exp_bytes[$];
  logic [DL-1:0] exp_words[$];
  int            wcyc[$];
  int            exp_ferr = 0, obs_ferr = 0;
  int            exp_ovf = 0, obs_ovf = 0;
  int            last_fall = 0, last_wv = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_frame(input logic [DL-1:0] v);
    exp_words.push_back(v);
    for (int b = 0; b < DL / 8; b++) exp_bytes.push_back(v[8*b +: 8]);
  endtask

  // One bit cell: 6 clks high (sdata changes with the rising edge), 6 clks low.
  task automatic send_bit(input logic b);
    @(negedge clk);
    sdata = b;
    bclk  = 1'b1;
    repeat (6) @(negedge clk);
    bclk      = 1'b0;
    last_fall = cyc;
    repeat (5) @(negedge clk);
  endtask

  task automatic start_frame();
    @(negedge clk);
    nsync = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic end_frame();
    @(negedge clk);
    bclk = 1'b1;
    repeat (6) @(negedge clk);
    nsync = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic send_frame(input logic [DL-1:0] v, input int nbits);
    start_frame();
    for (int i = 0; i < nbits; i++) send_bit(v[DL-1-i]);
    end_frame();
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents something.
  initial begin
    wait (mon_en);
    forever begin
      @(negedge clk);
      if (write) begin
        wcyc.push_back(cyc);
        if (exp_bytes.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_write: got %0h expected no write", wdata);
        end else begin
          check("wdata", {24'h0, wdata}, {24'h0, exp_bytes.pop_front()});
        end
      end
      if (word_valid) begin
        last_wv = cyc;
        if (exp_words.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_word_valid: got %0h expected no word", word);
        end else begin
          check("word", {8'h0, word}, {8'h0, exp_words.pop_front()});
        end
      end
      if (frame_err) obs_ferr++;
      if (overflow) obs_ovf++;
    end
  end

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int  n0;
    bit  found;
    rst = 1'b1; enable = 1'b1; sdata = 1'b0; bclk = 1'b1; nsync = 1'b1; full = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_wdata", {24'h0, wdata}, 32'h0);
    check("rst_word", {8'h0, word}, 32'h0);
    check("rst_flags", {27'h0, write, word_valid, frame_err, overflow, busy}, 32'h0);
    rst = 1'b0;
    mon_en = 1'b1;
    repeat (10) @(negedge clk);

    // T1: basic frame, latency and back-to-back writes
    n0 = wcyc.size();
    expect_frame(24'hA5C3F0);
    send_frame(24'hA5C3F0, DL);
    check("t1_latency", last_wv - last_fall, 4);
    check("t1_nwrites", wcyc.size() - n0, 3);
    if (wcyc.size() - n0 == 3) begin
      check("t1_consec0", wcyc[n0+1] - wcyc[n0], 1);
      check("t1_consec1", wcyc[n0+2] - wcyc[n0+1], 1);
    end
    check("t1_idle", {31'h0, busy}, 32'h0);

    // T2: short frame
    n0 = wcyc.size();
    exp_ferr++;
    send_frame(24'h3C3C3C, 10);
    check("t2_ferr", obs_ferr, exp_ferr);
    check("t2_word_kept", {8'h0, word}, 32'hA5C3F0);
    check("t2_nwrites", wcyc.size() - n0, 0);

    // T3: FIFO full stalls after the first byte
    n0 = wcyc.size();
    expect_frame(24'hA5C3F0);
    fork
      send_frame(24'hA5C3F0, DL);
      begin
        found = 1'b0;
        for (int k = 0; k < 600 && !found; k++) begin
          @(negedge clk);
          if (write) found = 1'b1;
        end
        check("t3_first_write_seen", {31'h0, found}, 32'h1);
        full = 1'b1;
        repeat (20) @(negedge clk);
        full = 1'b0;
      end
    join
    repeat (10) @(negedge clk);
    check("t3_nwrites", wcyc.size() - n0, 3);
    if (wcyc.size() - n0 == 3) check("t3_stall_gap", wcyc[n0+1] - wcyc[n0], 21);

    // T4: second frame while draining is dropped with overflow
    n0 = wcyc.size();
    expect_frame(24'h0F1E2D);
    fork
      send_frame(24'h0F1E2D, DL);
      begin
        found = 1'b0;
        for (int k = 0; k < 600 && !found; k++) begin
          @(negedge clk);
          if (word_valid) found = 1'b1;
        end
        check("t4_word_valid_seen", {31'h0, found}, 32'h1);
        full = 1'b1;
      end
    join
    exp_ovf++;
    send_frame(24'hDEADBE, DL);
    check("t4_overflow", obs_ovf, exp_ovf);
    check("t4_held", wcyc.size() - n0, 0);
    full = 1'b0;
    repeat (10) @(negedge clk);
    check("t4_drained", wcyc.size() - n0, 3);
    expect_frame(24'h5A5A01);
    send_frame(24'h5A5A01, DL);

    // T5: reset mid-frame
    start_frame();
    for (int i = 0; i < 12; i++) send_bit(1'(i % 2));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t5_rst_word", {8'h0, word}, 32'h0);
    check("t5_rst_flags", {27'h0, write, word_valid, frame_err, overflow, busy}, 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) send_bit(1'b1);
    end_frame();
    expect_frame(24'h123456);
    send_frame(24'h123456, DL);

    // T6: enable dropped mid-frame
    start_frame();
    for (int i = 0; i < 12; i++) send_bit(1'b0);
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check("t6_disabled_idle", {31'h0, busy}, 32'h0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    enable = 1'b1;
    for (int i = 0; i < 8; i++) send_bit(1'b1);
    end_frame();
    expect_frame(24'h0BCDEF);
    send_frame(24'h0BCDEF, DL);

    repeat (10) @(negedge clk);
    check("end_bytes_left", exp_bytes.size(), 0);
    check("end_words_left", exp_words.size(), 0);
    check("end_ferr", obs_ferr, exp_ferr);
    check("end_ovf", obs_ovf, exp_ovf);
    check("end_word", {8'h0, word}, 32'h0BCDEF);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
